// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-memory port between the IFU (read-only) and the LSU (read/write).
// One transaction outstanding at a time; round-robin grant on contention; all mem/resp outputs registered.
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_resp_valid,
    input  logic                  ifu_resp_ready,
    output logic [DATA_W-1:0]     ifu_rdata,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_wen,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wmask,
    output logic                  lsu_resp_valid,
    input  logic                  lsu_resp_ready,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  mem_valid,
    output logic                  mem_wen,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;          // 1 = LSU owns the transaction
    logic                last_grant_q, last_grant_d;  // 1 = LSU was granted last
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_valid_q, mem_valid_d;
    logic                mem_wen_q, mem_wen_d;
    logic                ifu_resp_valid_q, ifu_resp_valid_d;
    logic                lsu_resp_valid_q, lsu_resp_valid_d;
    logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
    logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;

    logic grant_ifu, grant_lsu;
    logic resp_hs;
    logic [DATA_W-1:0] rdata_sel;

    // On contention the requester that did not win last time gets the port.
    always_comb begin
        grant_lsu = lsu_req_valid & (~ifu_req_valid | ~last_grant_q);
        grant_ifu = ifu_req_valid & ~grant_lsu;
    end

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign ifu_req_ready = (state_q == StIdle) & grant_ifu & ~reset;
    assign lsu_req_ready = (state_q == StIdle) & grant_lsu & ~reset;

    assign resp_hs   = owner_q ? lsu_resp_ready : ifu_resp_ready;
    assign rdata_sel = wen_q ? '0 : mem_rdata;

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        last_grant_d     = last_grant_q;
        wen_d            = wen_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        wmask_d          = wmask_q;
        cnt_d            = cnt_q;
        mem_valid_d      = 1'b0;
        mem_wen_d        = 1'b0;
        ifu_resp_valid_d = ifu_resp_valid_q;
        lsu_resp_valid_d = lsu_resp_valid_q;
        ifu_rdata_d      = ifu_rdata_q;
        lsu_rdata_d      = lsu_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (grant_ifu || grant_lsu) begin
                    owner_d      = grant_lsu;
                    last_grant_d = grant_lsu;
                    wen_d        = grant_lsu & lsu_wen;
                    addr_d       = grant_lsu ? lsu_addr : ifu_addr;
                    wdata_d      = grant_lsu ? lsu_wdata : '0;
                    wmask_d      = grant_lsu ? lsu_wmask : '0;
                    mem_valid_d  = 1'b1;
                    mem_wen_d    = grant_lsu & lsu_wen;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = CNT_LOAD;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    if (owner_q) begin
                        lsu_rdata_d      = rdata_sel;
                        lsu_resp_valid_d = 1'b1;
                    end else begin
                        ifu_rdata_d      = rdata_sel;
                        ifu_resp_valid_d = 1'b1;
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StResp: begin
                if (resp_hs) begin
                    ifu_resp_valid_d = 1'b0;
                    lsu_resp_valid_d = 1'b0;
                    state_d          = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= StIdle;
            owner_q          <= 1'b0;
            last_grant_q     <= 1'b0;
            wen_q            <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            wmask_q          <= '0;
            cnt_q            <= '0;
            mem_valid_q      <= 1'b0;
            mem_wen_q        <= 1'b0;
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            ifu_rdata_q      <= '0;
            lsu_rdata_q      <= '0;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            last_grant_q     <= last_grant_d;
            wen_q            <= wen_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            wmask_q          <= wmask_d;
            cnt_q            <= cnt_d;
            mem_valid_q      <= mem_valid_d;
            mem_wen_q        <= mem_wen_d;
            ifu_resp_valid_q <= ifu_resp_valid_d;
            lsu_resp_valid_q <= lsu_resp_valid_d;
            ifu_rdata_q      <= ifu_rdata_d;
            lsu_rdata_q      <= lsu_rdata_d;
        end
    end

    assign mem_valid      = mem_valid_q;
    assign mem_wen        = mem_wen_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;
    assign ifu_resp_valid = ifu_resp_valid_q;
    assign lsu_resp_valid = lsu_resp_valid_q;
    assign ifu_rdata      = ifu_rdata_q;
    assign lsu_rdata      = lsu_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LATENCY=1, one at MEM_LATENCY=3,
// each attached to a small RAM model whose read data is only valid in the cycle it is due.
module tb_mem_port_arbiter;

    localparam logic [31:0] BAD = 32'hBAD0_BAD0;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: MEM_LATENCY = 1
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_valid, mem_wen;
    logic [31:0] mem_addr, mem_wdata, rd1;
    logic [3:0]  mem_wmask;

    // Instance B: MEM_LATENCY = 3
    logic        b_ifu_req_valid, b_ifu_req_ready, b_ifu_resp_valid;
    logic [31:0] b_ifu_addr, b_ifu_rdata;
    logic        b_lsu_req_ready, b_lsu_resp_valid;
    logic [31:0] b_lsu_rdata;
    logic        b_mem_valid, b_mem_wen;
    logic [31:0] b_mem_addr, b_mem_wdata, rd3;
    logic [3:0]  b_mem_wmask;

    mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) u_dut_a (
        .clock(clock), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(rd1)
    );

    mem_port_arbiter #(.MEM_LATENCY(3), .ADDR_W(32), .DATA_W(32)) u_dut_b (
        .clock(clock), .reset(reset),
        .ifu_req_valid(b_ifu_req_valid), .ifu_req_ready(b_ifu_req_ready), .ifu_addr(b_ifu_addr),
        .ifu_resp_valid(b_ifu_resp_valid), .ifu_resp_ready(1'b1), .ifu_rdata(b_ifu_rdata),
        .lsu_req_valid(1'b0), .lsu_req_ready(b_lsu_req_ready), .lsu_wen(1'b0),
        .lsu_addr(32'h0), .lsu_wdata(32'h0), .lsu_wmask(4'h0),
        .lsu_resp_valid(b_lsu_resp_valid), .lsu_resp_ready(1'b1), .lsu_rdata(b_lsu_rdata),
        .mem_valid(b_mem_valid), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask), .mem_rdata(rd3)
    );

    // RAM model A: byte-masked writes, read data valid only in the cycle after the strobe.
    logic [31:0] mem1 [16];
    always @(posedge clock) begin
        if (reset) begin
            mem1[0] <= 32'h0000_0413;
            mem1[1] <= 32'h0000_0513;
            mem1[2] <= 32'h0000_0613;
            mem1[4] <= 32'h1111_1111;
        end else if (mem_valid && mem_wen) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) mem1[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        rd1 <= (mem_valid && !mem_wen) ? mem1[mem_addr[5:2]] : BAD;
    end

    // RAM model B: three-stage read pipeline, data = addr ^ 0xA5A50000 only when due.
    logic        p1, p2;
    logic [31:0] a1, a2;
    always @(posedge clock) begin
        p1  <= b_mem_valid && !b_mem_wen;
        p2  <= p1;
        a1  <= b_mem_addr;
        a2  <= a1;
        rd3 <= p2 ? (a2 ^ 32'hA5A5_0000) : BAD;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        logic exp_lsu;
        bit   seen;
        ifu_req_valid = 0; ifu_addr = 0; ifu_resp_ready = 1;
        lsu_req_valid = 0; lsu_wen = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
        lsu_resp_ready = 1;
        b_ifu_req_valid = 0; b_ifu_addr = 0;
        do_reset();

        chk("reset_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("reset_ifu_resp", {63'd0, ifu_resp_valid}, 64'd0);
        chk("reset_lsu_resp", {63'd0, lsu_resp_valid}, 64'd0);

        // 1: IFU read, latency 1
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000; #1;
        chk("t1_ifu_ready", {63'd0, ifu_req_ready}, 64'd1);
        chk("t1_lsu_ready", {63'd0, lsu_req_ready}, 64'd0);
        tick(); ifu_req_valid = 0;
        chk("t1_mem_valid", {63'd0, mem_valid}, 64'd1);
        chk("t1_mem_wen", {63'd0, mem_wen}, 64'd0);
        chk("t1_mem_addr", {32'd0, mem_addr}, 64'h8000_0000);
        tick();
        chk("t1_mem_valid_off", {63'd0, mem_valid}, 64'd0);
        chk("t1_resp_early", {63'd0, ifu_resp_valid}, 64'd0);
        tick();
        chk("t1_resp_valid", {63'd0, ifu_resp_valid}, 64'd1);
        chk("t1_rdata", {32'd0, ifu_rdata}, 64'h0000_0413);
        chk("t1_lsu_resp", {63'd0, lsu_resp_valid}, 64'd0);
        tick();
        chk("t1_resp_cleared", {63'd0, ifu_resp_valid}, 64'd0);

        // 2: LSU store, then load back to see the mask applied
        lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_0010;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011; #1;
        chk("t2_lsu_ready", {63'd0, lsu_req_ready}, 64'd1);
        tick(); lsu_req_valid = 0;
        chk("t2_mem_valid", {63'd0, mem_valid}, 64'd1);
        chk("t2_mem_wen", {63'd0, mem_wen}, 64'd1);
        chk("t2_mem_addr", {32'd0, mem_addr}, 64'h8000_0010);
        chk("t2_mem_wdata", {32'd0, mem_wdata}, 64'hDEAD_BEEF);
        chk("t2_mem_wmask", {60'd0, mem_wmask}, 64'h3);
        tick();
        chk("t2_wen_off", {63'd0, mem_wen}, 64'd0);
        tick();
        chk("t2_ack_valid", {63'd0, lsu_resp_valid}, 64'd1);
        chk("t2_ack_rdata", {32'd0, lsu_rdata}, 64'd0);
        chk("t2_ifu_resp", {63'd0, ifu_resp_valid}, 64'd0);
        tick();
        lsu_req_valid = 1; lsu_wen = 0;
        tick(); lsu_req_valid = 0;
        tick(); tick();
        chk("t2_load_valid", {63'd0, lsu_resp_valid}, 64'd1);
        chk("t2_load_rdata", {32'd0, lsu_rdata}, 64'h1111_BEEF);
        tick();

        // 3: contention from reset -> LSU, IFU, LSU, IFU
        do_reset();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_0008; #1;
        exp_lsu = 1'b1;
        for (int k = 0; k < 4; k++) begin
            seen = 0;
            for (int c = 0; c < 10 && !seen; c++) begin
                if (ifu_req_ready || lsu_req_ready) seen = 1;
                else tick();
            end
            chk($sformatf("t3_grant%0d_seen", k), {63'd0, seen}, 64'd1);
            chk($sformatf("t3_grant%0d_lsu", k), {63'd0, lsu_req_ready}, {63'd0, exp_lsu});
            chk($sformatf("t3_grant%0d_ifu", k), {63'd0, ifu_req_ready}, {63'd0, !exp_lsu});
            tick();
            chk($sformatf("t3_busy%0d", k), {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
            exp_lsu = !exp_lsu;
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        tick(); tick(); tick();

        // 4: IFU response backpressure blocks the waiting LSU
        ifu_resp_ready = 0; ifu_req_valid = 1; ifu_addr = 32'h8000_0004; #1;
        chk("t4_ifu_ready", {63'd0, ifu_req_ready}, 64'd1);
        tick(); ifu_req_valid = 0;
        lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_0008;
        tick(); tick();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t4_hold_valid%0d", c), {63'd0, ifu_resp_valid}, 64'd1);
            chk($sformatf("t4_hold_rdata%0d", c), {32'd0, ifu_rdata}, 64'h0000_0513);
            chk($sformatf("t4_lsu_blocked%0d", c), {63'd0, lsu_req_ready}, 64'd0);
            tick();
        end
        ifu_resp_ready = 1; #1;
        chk("t4_lsu_blocked_last", {63'd0, lsu_req_ready}, 64'd0);
        tick();
        chk("t4_ifu_consumed", {63'd0, ifu_resp_valid}, 64'd0);
        chk("t4_lsu_ready", {63'd0, lsu_req_ready}, 64'd1);
        tick(); lsu_req_valid = 0;
        tick(); tick();
        chk("t4_lsu_valid", {63'd0, lsu_resp_valid}, 64'd1);
        chk("t4_lsu_rdata", {32'd0, lsu_rdata}, 64'h0000_0613);
        tick();

        // 5: latency 3 instance
        b_ifu_req_valid = 1; b_ifu_addr = 32'h0000_0040; #1;
        chk("t5_ready", {63'd0, b_ifu_req_ready}, 64'd1);
        tick(); b_ifu_req_valid = 0;
        chk("t5_mem_valid", {63'd0, b_mem_valid}, 64'd1);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk($sformatf("t5_n%0d_mem_valid", c), {63'd0, b_mem_valid}, 64'd0);
            chk($sformatf("t5_n%0d_resp", c), {63'd0, b_ifu_resp_valid}, 64'd0);
        end
        tick();
        chk("t5_resp_valid", {63'd0, b_ifu_resp_valid}, 64'd1);
        chk("t5_rdata", {32'd0, b_ifu_rdata}, 64'hA5A5_0040);
        chk("t5_lsu_resp", {63'd0, b_lsu_resp_valid}, 64'd0);
        tick();
        chk("t5_resp_cleared", {63'd0, b_ifu_resp_valid}, 64'd0);

        // 6: reset asserted during WAIT
        ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
        tick(); tick();
        reset = 1; #1;
        chk("t6_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("t6_ifu_ready", {63'd0, ifu_req_ready}, 64'd0);
        chk("t6_mem_addr", {32'd0, mem_addr}, 64'd0);
        @(posedge clock); #2;
        chk("t6_resp_after_edge", {63'd0, ifu_resp_valid}, 64'd0);
        reset = 0; #1;
        chk("t6_ready_after", {63'd0, ifu_req_ready}, 64'd1);
        tick(); ifu_req_valid = 0;
        tick(); tick();
        chk("t6_resp_valid", {63'd0, ifu_resp_valid}, 64'd1);
        chk("t6_rdata", {32'd0, ifu_rdata}, 64'h0000_0513);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
